// File: rtl/apb_pkg.sv
// Shared APB definitions for the command master: bus widths and FSM state type.
package apb_pkg;

   localparam int unsigned APB_AW = 16;
   localparam int unsigned APB_DW = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } apb_state_e;

endpackage : apb_pkg

// File: rtl/apb_cmd_master.sv
// Single-outstanding host-command to APB master bridge.
// Optional ACCESS-phase abort enabled by defining APB_TIMEOUT_EN.
module apb_cmd_master
   import apb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [APB_AW-1:0] cmd_addr,
   input  logic [APB_DW-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [APB_DW-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [APB_AW-1:0] apb_addr,
   output logic              apb_selx,
   output logic              apb_enable,
   output logic              apb_write,
   output logic [APB_DW-1:0] apb_wdata,
   input  logic              apb_ready,
   input  logic [APB_DW-1:0] apb_rdata,
   input  logic              apb_slverr
);

   apb_state_e state, state_nxt;
   logic       xfer_done;
   logic       xfer_abort;

   assign xfer_done = (state == ST_ACCESS) && apb_ready;

`ifdef APB_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TO_W-1:0] to_cnt;

   // to_cnt holds the number of ACCESS cycles already elapsed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt <= '0;
      end else if (state == ST_SETUP) begin
         to_cnt <= '0;
      end else if (state == ST_ACCESS) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   assign xfer_abort = (state == ST_ACCESS) && !apb_ready &&
                       (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
   assign xfer_abort = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (cmd_valid)               state_nxt = ST_SETUP;
         ST_SETUP:                               state_nxt = ST_ACCESS;
         ST_ACCESS: if (xfer_done || xfer_abort) state_nxt = ST_RESP;
         ST_RESP:   if (rsp_ready)               state_nxt = ST_IDLE;
         default:                                state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready  = 1'b0;
      rsp_valid  = 1'b0;
      apb_selx   = 1'b0;
      apb_enable = 1'b0;
      case (state)
         ST_IDLE:   cmd_ready = 1'b1;
         ST_SETUP:  apb_selx  = 1'b1;
         ST_ACCESS: begin
            apb_selx   = 1'b1;
            apb_enable = 1'b1;
         end
         ST_RESP:   rsp_valid = 1'b1;
         default:   ;
      endcase
   end

   // Command fields load only on acceptance, so they stay put through SETUP/ACCESS
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         apb_write <= 1'b0;
         apb_addr  <= '0;
         apb_wdata <= '0;
      end else if (state == ST_IDLE && cmd_valid) begin
         apb_write <= cmd_write;
         apb_addr  <= cmd_addr;
         apb_wdata <= cmd_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (xfer_done) begin
         rsp_rdata <= apb_write ? '0 : apb_rdata;
         rsp_err   <= apb_slverr;
      end else if (xfer_abort) begin
         rsp_rdata <= '0;
         rsp_err   <= 1'b1;
      end
   end

endmodule : apb_cmd_master
